// File: rtl/capture_pkg.sv
// Shared types and constants for the prestore capture path: FSM states,
// the 4-bit I/Q sample layout and the samples-per-word packing factor.
package capture_pkg;

  localparam int SPW    = 8;
  localparam int IDX_W  = 3;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_PULSE = 2'd1,
    FILL       = 2'd2,
    DONE       = 2'd3
  } state_e;

  // First member lands in the MSB, so a sample packs as {Q_mag,Q_sig,I_mag,I_sig}.
  typedef struct packed {
    logic q_mag;
    logic q_sig;
    logic i_mag;
    logic i_sig;
  } sample_t;

  function automatic sample_t make_sample(input logic i_sig, input logic i_mag,
                                          input logic q_sig, input logic q_mag);
    sample_t s;
    s.q_mag = q_mag;
    s.q_sig = q_sig;
    s.i_mag = i_mag;
    s.i_sig = i_sig;
    return s;
  endfunction

endpackage

// File: rtl/sample_packer4x8.sv
// Packs eight 4-bit samples into one 32-bit word, sample k at bits [4k+3:4k];
// raises ready for one cycle after the word is complete, with the word held.
module sample_packer4x8
  import capture_pkg::*;
#(
  parameter int SPW_P = SPW
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clear,
  input  logic                accept,
  input  sample_t             sample,
  output logic                ready,
  output logic [WORD_W-1:0]   word
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPW_P - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [IDX_W-1:0]  index;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] acc_n;

  always_comb begin
    acc_n = acc;
    acc_n[{index, 2'b00} +: 4] = sample;
  end

  // The completed word goes to a separate register so the next word can
  // start assembling in the very cycle the previous one is being written.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      index <= '0;
      acc   <= '0;
      word  <= '0;
      ready <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (clear) begin
        index <= '0;
        acc   <= '0;
      end else if (accept) begin
        index <= index + IDX_ONE;
        if (index == LAST_IDX) begin
          word  <= acc_n;
          acc   <= '0;
          ready <= 1'b1;
        end else begin
          acc <= acc_n;
        end
      end
    end
  end

endmodule

// File: rtl/prestore_capture.sv
// Captures a time-pulse-aligned stream of 2-bit I/Q samples into a 32-bit
// single-port RAM, eight samples per word, for a programmable word count.
module prestore_capture #(
  parameter int ADDR_W = 10,
  parameter int SPW    = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] len,
  input  logic              I_sig,
  input  logic              I_mag,
  input  logic              Q_sig,
  input  logic              Q_mag,
  input  logic              valid,
  input  logic              time_pulse,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words,
  output logic [1:0]        fsm_state
);

  import capture_pkg::*;

  // Handshake: arm/abort are single-cycle requests (abort wins over arm),
  // valid qualifies the sample pins every cycle with no backpressure, and
  // mem_we is a one-cycle write strobe with mem_addr/mem_wdata stable alongside.

  localparam logic [ADDR_W:0]   WORDS_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state, state_n;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W:0]   words_inc;
  logic [ADDR_W:0]   target;
  logic              start;
  logic              accept;
  logic              clear;
  logic              ready;
  logic [31:0]       word;
  sample_t           sample;

  assign sample    = make_sample(I_sig, I_mag, Q_sig, Q_mag);
  assign target    = (len_q == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, len_q};
  assign words_inc = words_q + WORDS_ONE;

  assign start  = arm && !abort && (state == IDLE || state == DONE);
  assign accept = valid && !abort &&
                  (state == FILL || (state == WAIT_PULSE && time_pulse));
  assign clear  = abort || !(state == FILL || state == WAIT_PULSE);

  // Gating with resetn drops a pending write in the very cycle reset arrives.
  assign mem_we    = ready && resetn && (state == FILL);
  assign mem_addr  = addr;
  assign mem_wdata = word;
  assign busy      = (state == WAIT_PULSE) || (state == FILL);
  assign done      = (state == DONE);
  assign words     = words_q;
  assign fsm_state = state;

  sample_packer4x8 #(
    .SPW_P (SPW)
  ) u_packer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .accept (accept),
    .sample (sample),
    .ready  (ready),
    .word   (word)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (start) state_n = WAIT_PULSE;
      WAIT_PULSE: begin
        if (abort)           state_n = IDLE;
        else if (time_pulse) state_n = FILL;
      end
      FILL: begin
        if (abort)                              state_n = IDLE;
        else if (mem_we && words_inc == target) state_n = DONE;
      end
      DONE: begin
        if (abort)      state_n = IDLE;
        else if (start) state_n = WAIT_PULSE;
      end
      default:          state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      len_q   <= '0;
      addr    <= '0;
      words_q <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        len_q   <= len;
        addr    <= '0;
        words_q <= '0;
      end else if (mem_we) begin
        addr    <= addr + ADDR_ONE;
        words_q <= words_inc;
      end
    end
  end

endmodule

// File: tb/tb_prestore_capture.sv
// Bench for prestore_capture: control vector table, directed capture
// sequences and randomized captures checked against a word-level model.
module tb_prestore_capture;

  import capture_pkg::*;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              resetn, arm, abort, valid, time_pulse;
  logic              I_sig, I_mag, Q_sig, Q_mag;
  logic [ADDR_W-1:0] len;
  logic              mem_we, busy, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   words;
  logic [1:0]        fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  logic [ADDR_W+31:0] exp_q[$];
  int                 exp_cyc[$];
  logic [ADDR_W+31:0] got_q[$];
  int                 got_cyc[$];
  logic [3:0]         cap_s[$];
  int                 cap_c[$];

  prestore_capture #(.ADDR_W(ADDR_W), .SPW(8)) dut (
    .clk(clk), .resetn(resetn), .arm(arm), .abort(abort), .len(len),
    .I_sig(I_sig), .I_mag(I_mag), .Q_sig(Q_sig), .Q_mag(Q_mag),
    .valid(valid), .time_pulse(time_pulse),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .words(words), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_q.push_back({mem_addr, mem_wdata});
      got_cyc.push_back(cycle);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    arm = 1'b0; abort = 1'b0; valid = 1'b0; time_pulse = 1'b0;
    {Q_mag, Q_sig, I_mag, I_sig} = 4'h0;
  endtask

  // One valid sample cycle; the sample is logged as part of the capture.
  task automatic send(input logic [3:0] s, input logic tp);
    valid = 1'b1; time_pulse = tp;
    {Q_mag, Q_sig, I_mag, I_sig} = s;
    cap_s.push_back(s);
    cap_c.push_back(cycle);
    tick();
    set_idle();
  endtask

  task automatic do_arm(input int l);
    set_idle();
    len = ADDR_W'(l % DEPTH);
    arm = 1'b1;
    tick();
    set_idle();
  endtask

  task automatic do_abort();
    set_idle();
    abort = 1'b1;
    tick();
    set_idle();
  endtask

  // ---------------- reference model / scoreboard ----------------
  function automatic logic [31:0] pack8(input int base);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[4*k +: 4] = cap_s[base + k];
    return w;
  endfunction

  // Word w of a capture is samples 8w..8w+7, written to address w mod depth
  // one cycle after its last sample; no more than the programmed length.
  task automatic build_expected(input int l_eff);
    int nw;
    nw = cap_s.size() / 8;
    if (nw > l_eff) nw = l_eff;
    for (int w = 0; w < nw; w++) begin
      exp_q.push_back({ADDR_W'(w % DEPTH), pack8(8 * w)});
      exp_cyc.push_back(cap_c[8*w + 7] + 1);
    end
  endtask

  task automatic compare_writes(input string name);
    check({name, "_write_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_write%0d_addr_data", name, i), 64'(got_q[i]), 64'(exp_q[i]));
      check($sformatf("%s_write%0d_cycle", name, i), 64'(got_cyc[i]), 64'(exp_cyc[i]));
    end
    exp_q.delete(); exp_cyc.delete(); got_q.delete(); got_cyc.delete();
    cap_s.delete(); cap_c.delete();
  endtask

  task automatic check_status(input string name, input state_e st, input logic b,
                              input logic d, input int w);
    check({name, "_state"}, 64'(fsm_state), 64'(st));
    check({name, "_busy"},  64'(busy), 64'(b));
    check({name, "_done"},  64'(done), 64'(d));
    check({name, "_words"}, 64'(words), 64'(w));
  endtask

  // ---------------- control vector table ----------------
  typedef struct {
    logic   arm;
    logic   abort;
    logic   tp;
    state_e st;
    logic   busy;
    logic   done;
  } vec_t;

  vec_t vecs[11];

  initial begin
    set_idle();
    len    = '0;
    resetn = 1'b0;

    // Reset state
    tick(); tick();
    check_status("reset", IDLE, 1'b0, 1'b0, 0);
    check("reset_mem_we",    64'(mem_we),    64'h0);
    check("reset_mem_addr",  64'(mem_addr),  64'h0);
    check("reset_mem_wdata", 64'(mem_wdata), 64'h0);
    resetn = 1'b1;
    tick();

    // Arm/abort/time_pulse conflicts; valid stays low so nothing is captured.
    vecs[0]  = '{arm:0, abort:0, tp:0, st:IDLE,       busy:0, done:0};
    vecs[1]  = '{arm:0, abort:1, tp:0, st:IDLE,       busy:0, done:0};
    vecs[2]  = '{arm:1, abort:0, tp:0, st:WAIT_PULSE, busy:1, done:0};
    vecs[3]  = '{arm:1, abort:0, tp:0, st:WAIT_PULSE, busy:1, done:0};
    vecs[4]  = '{arm:1, abort:1, tp:0, st:IDLE,       busy:0, done:0};
    vecs[5]  = '{arm:1, abort:0, tp:0, st:WAIT_PULSE, busy:1, done:0};
    vecs[6]  = '{arm:0, abort:0, tp:1, st:FILL,       busy:1, done:0};
    vecs[7]  = '{arm:0, abort:0, tp:1, st:FILL,       busy:1, done:0};
    vecs[8]  = '{arm:1, abort:0, tp:0, st:FILL,       busy:1, done:0};
    vecs[9]  = '{arm:1, abort:1, tp:0, st:IDLE,       busy:0, done:0};
    vecs[10] = '{arm:1, abort:1, tp:1, st:IDLE,       busy:0, done:0};
    len = ADDR_W'(3);
    for (int i = 0; i < 11; i++) begin
      set_idle();
      arm = vecs[i].arm; abort = vecs[i].abort; time_pulse = vecs[i].tp;
      tick();
      check_status($sformatf("vec%0d", i), vecs[i].st, vecs[i].busy, vecs[i].done, 0);
      check($sformatf("vec%0d_mem_addr", i), 64'(mem_addr), 64'h0);
    end
    set_idle();
    compare_writes("vectors");

    // Pulse-aligned capture, len=2. Nibble 6 is I=+3/Q=-1 and nibble 9 is the
    // mirrored pair, alternating to give 0x96969696 per word.
    do_arm(2);
    for (int i = 0; i < 16; i++) send((i % 2 == 0) ? 4'h6 : 4'h9, i == 0);
    check("aligned_last_wdata", 64'(mem_wdata), 64'h96969696);
    check("aligned_last_we",    64'(mem_we),    64'h1);
    tick();
    check_status("aligned_done", DONE, 1'b0, 1'b1, 2);
    build_expected(2);
    for (int i = 0; i < 9; i++) begin
      valid = 1'b1; time_pulse = (i == 3);
      {Q_mag, Q_sig, I_mag, I_sig} = 4'(i);
      tick();
    end
    set_idle();
    tick();
    check_status("aligned_ignore", DONE, 1'b0, 1'b1, 2);
    compare_writes("aligned");

    // Pulse without valid, re-armed straight from DONE, len=1.
    do_arm(1);
    check_status("rearm_from_done", WAIT_PULSE, 1'b1, 1'b0, 0);
    time_pulse = 1'b1;
    tick();
    set_idle();
    for (int k = 0; k < 8; k++) send(4'(k), 1'b0);
    tick();
    check_status("nopulse_done", DONE, 1'b0, 1'b1, 1);
    exp_q.push_back({ADDR_W'(0), 32'h76543210});
    exp_cyc.push_back(cap_c[7] + 1);
    compare_writes("nopulse");

    // Abort mid-word, len=4: word 0 written, 5 samples of word 1 dropped.
    do_abort();
    check_status("done_abort", IDLE, 1'b0, 1'b0, 1);
    do_arm(4);
    for (int i = 0; i < 13; i++) send(4'($urandom_range(0, 15)), i == 0);
    do_abort();
    check_status("midword_abort", IDLE, 1'b0, 1'b0, 1);
    tick(); tick();
    build_expected(4);
    compare_writes("midword");

    // Arm during FILL is ignored: addresses run 0,1,2 across the arm.
    do_arm(3);
    for (int i = 0; i < 24; i++) begin
      if (i == 11) arm = 1'b1;
      send(4'($urandom_range(0, 15)), i == 0);
    end
    tick();
    check_status("arm_in_fill", DONE, 1'b0, 1'b1, 3);
    build_expected(3);
    compare_writes("arm_in_fill");

    // Full-depth wrap with len=0, then a re-arm must restart at address 0.
    do_abort();
    do_arm(0);
    for (int i = 0; i < 64; i++) send(4'($urandom_range(0, 15)), i == 0);
    tick();
    check_status("wrap_done", DONE, 1'b0, 1'b1, DEPTH);
    build_expected(DEPTH);
    compare_writes("wrap");
    do_arm(1);
    for (int i = 0; i < 8; i++) send(4'($urandom_range(0, 15)), i == 0);
    tick();
    check_status("wrap_rearm", DONE, 1'b0, 1'b1, 1);
    build_expected(1);
    compare_writes("wrap_rearm");

    // Gapped valid; reset lands in the would-be write cycle of word 0.
    do_abort();
    do_arm(2);
    for (int i = 0; i < 8; i++) begin
      send(4'($urandom_range(0, 15)), i == 0);
      if (i < 7) begin tick(); tick(); end
    end
    resetn = 1'b0;
    #2;
    check("reset_suppress_we", 64'(mem_we), 64'h0);
    tick();
    check_status("gap_reset", IDLE, 1'b0, 1'b0, 0);
    check("gap_reset_addr",  64'(mem_addr),  64'h0);
    check("gap_reset_wdata", 64'(mem_wdata), 64'h0);
    check("gap_reset_we",    64'(mem_we),    64'h0);
    resetn = 1'b1;
    tick();
    cap_s.delete(); cap_c.delete();
    compare_writes("gap_reset");

    // Randomized captures against the word-level model.
    for (int it = 0; it < 12; it++) begin
      int l_eff, n, exp_words;
      logic aligned;
      l_eff   = $urandom_range(1, DEPTH);
      aligned = 1'($urandom_range(0, 1));
      n       = $urandom_range(0, 8 * l_eff + 10);
      do_arm(l_eff);
      if (!aligned) begin
        time_pulse = 1'b1;
        tick();
        set_idle();
      end
      for (int i = 0; i < n; i++) begin
        send(4'($urandom_range(0, 15)), (aligned && i == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          time_pulse = 1'($urandom_range(0, 1));
          tick();
          set_idle();
        end
      end
      if (aligned && n == 0) begin
        time_pulse = 1'b1;
        tick();
        set_idle();
      end
      tick(); tick();
      exp_words = (n / 8 < l_eff) ? n / 8 : l_eff;
      check($sformatf("rand%0d_done", it),  64'(done),  64'(n >= 8 * l_eff));
      check($sformatf("rand%0d_words", it), 64'(words), 64'(exp_words));
      build_expected(l_eff);
      do_abort();
      check($sformatf("rand%0d_idle", it), 64'(fsm_state), 64'(IDLE));
      compare_writes($sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
